// File: rtl/router_output_arbiter.sv
// Round-robin, wormhole-locking arbiter feeding one registered router output stage.
// Optional stall watchdog on the locked owner: define ROUTER_ARB_WATCHDOG_EN.
module router_output_arbiter #(
  parameter int NumInputs     = 5,
  parameter int Width         = 8,
  parameter int TimeoutCycles = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumInputs-1:0]           in_req,
  input  logic [NumInputs-1:0]           in_empty,
  input  logic [NumInputs*Width-1:0]     in_data,
  output logic [NumInputs-1:0]           in_rdreq,
  output logic                           out_valid,
  output logic [Width-1:0]               out_data,
  input  logic                           out_ready,
  output logic [$clog2(NumInputs)-1:0]   grant_owner,
  output logic                           err_timeout,
  output logic                           dbg_locked
);
  // Handshakes: in_rdreq[i] pops FIFO i at the next rising edge and is only raised
  // while FIFO i is non-empty; an output flit transfers on any edge where
  // out_valid & out_ready, and out_valid/out_data hold until that happens.
  localparam int IdxW = $clog2(NumInputs);
  localparam logic [IdxW:0] NumW = (IdxW+1)'(NumInputs);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state;
  logic [IdxW-1:0]     rr_ptr;
  logic [IdxW-1:0]     owner;
  logic [NumInputs-1:0] eligible;
  logic                slot_free;
  logic                grant_found;
  logic [IdxW-1:0]     grant_idx;
  logic [IdxW:0]       scan;
  logic                pop;
  logic [IdxW-1:0]     sel;
  logic [Width-1:0]    pop_data;
  logic                pop_tail;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
    return (x == IdxW'(NumInputs - 1)) ? '0 : x + IdxW'(1);
  endfunction

  assign eligible    = in_req & ~in_empty;
  assign slot_free   = ~out_valid | out_ready;
  assign grant_owner = owner;
  assign dbg_locked  = (state == LOCKED);
  assign pop_tail    = pop_data[Width-1];

  // First eligible input at or after rr_ptr, wrapping modulo NumInputs.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NumInputs; k++) begin
      scan = {1'b0, rr_ptr} + (IdxW+1)'(k);
      if (scan >= NumW) scan = scan - NumW;
      if (!grant_found && eligible[scan[IdxW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[IdxW-1:0];
      end
    end
  end

  // Reset gates the pop so a held lock cannot drain its FIFO during rst.
  always_comb begin
    sel = (state == LOCKED) ? owner : grant_idx;
    pop = 1'b0;
    if (!rst && slot_free) begin
      if (state == IDLE) pop = grant_found;
      else               pop = ~in_empty[owner];
    end
  end

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (sel == IdxW'(i)) pop_data = in_data[i*Width +: Width];
    end
  end

  always_comb begin
    in_rdreq = '0;
    for (int i = 0; i < NumInputs; i++) begin
      in_rdreq[i] = pop && (sel == IdxW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= pop_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            if (pop_tail) rr_ptr <= next_idx(grant_idx);
            else begin
              state <= LOCKED;
              owner <= grant_idx;
            end
          end
        end
        LOCKED: begin
          if (pop && pop_tail) begin
            state  <= IDLE;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt;

  // Counts cycles the locked owner sits empty; the error is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != LOCKED || pop)              wd_cnt <= '0;
      else if (in_empty[owner] && wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;
      if (wd_cnt == 8'(TimeoutCycles)) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: behavioural input FIFOs, an expected
// flit queue checked at every output handshake, and pop-order/timing checks.
module tb_router_output_arbiter;
  localparam int N = 5;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_req;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_rdreq;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [2:0]     grant_owner;
  logic           err_timeout;
  logic           dbg_locked;

  always #5 clk = ~clk;

  router_output_arbiter #(.NumInputs(N), .Width(W), .TimeoutCycles(10)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_empty(in_empty), .in_data(in_data),
    .in_rdreq(in_rdreq), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_owner(grant_owner), .err_timeout(err_timeout),
    .dbg_locked(dbg_locked)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [W-1:0] exp_q[$];
  int           pop_src[$];
  int           pop_cyc[$];
  logic [W-1:0] mem [N][32];
  int           wr_p [N];
  int           rd_p [N];
  logic [N-1:0] req_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Flit = {tail, head, src[2:0], seq[2:0]}
  function automatic logic [W-1:0] mk_flit(input int s, input int k, input int len, input int seq0);
    logic [2:0] s3;
    logic [2:0] q3;
    s3 = 3'(s);
    q3 = 3'(seq0 + k);
    return {(k == len - 1), (k == 0), s3, q3};
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      in_empty[i]         = (wr_p[i] == rd_p[i]);
      in_data[i*W +: W]   = mem[i][rd_p[i] % 32];
      in_req[i]           = req_en[i];
    end
  endtask

  task automatic load_flits(input int s, input int len, input int seq0, input int k_lo, input int k_hi);
    for (int k = k_lo; k <= k_hi; k++) begin
      mem[s][wr_p[s] % 32] = mk_flit(s, k, len, seq0);
      wr_p[s]++;
    end
    refresh();
  endtask

  task automatic exp_pkt(input int s, input int len, input int seq0);
    for (int k = 0; k < len; k++) exp_q.push_back(mk_flit(s, k, len, seq0));
  endtask

  // One clock: check at negedge, then apply FIFO pops just after posedge.
  task automatic cycle();
    logic [N-1:0] rd;
    logic [W-1:0] e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_flit", {24'b0, out_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("out_data", {24'b0, out_data}, {24'b0, e});
      end
    end
    rd = in_rdreq;
    chk("rdreq_onehot", {31'b0, ($countones(rd) <= 1)}, 1);
    chk("rdreq_on_empty", {27'b0, rd & in_empty}, 0);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i] === 1'b1) begin
        if (wr_p[i] != rd_p[i]) rd_p[i]++;
        pop_src.push_back(i);
        pop_cyc.push_back(cyc);
      end
    end
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    pop_src.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_en = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end
    refresh();
    run(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_pops(input string tag, input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int n);
    int exp_s[5];
    exp_s = '{a0, a1, a2, a3, a4};
    chk({tag, "_count"}, pop_src.size(), n);
    if (pop_src.size() >= n) begin
      for (int k = 0; k < n && k < 5; k++) chk({tag, "_src"}, pop_src[k], exp_s[k]);
    end
  endtask

  task automatic chk_contig(input string tag);
    for (int k = 1; k < pop_cyc.size(); k++) chk(tag, pop_cyc[k], pop_cyc[k-1] + 1);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    out_ready = 1'b1;
    req_en = '0;
    in_req = '0;
    in_empty = '1;
    in_data = '0;
    do_reset();

    // Reset state
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {24'b0, out_data}, 0);
    chk("rst_in_rdreq", {27'b0, in_rdreq}, 0);
    chk("rst_err_timeout", {31'b0, err_timeout}, 0);
    chk("rst_grant_owner", {29'b0, grant_owner}, 0);
    chk("rst_locked", {31'b0, dbg_locked}, 0);

    // Single-flit packets on inputs 0 and 2: popped in consecutive cycles
    clear_logs();
    c0 = cyc;
    load_flits(0, 1, 1, 0, 0);
    load_flits(2, 1, 1, 0, 0);
    req_en = 5'b00101;
    refresh();
    exp_pkt(0, 1, 1);
    exp_pkt(2, 1, 1);
    run(4);
    chk_pops("t1_pops", 0, 2, 0, 0, 0, 2);
    if (pop_cyc.size() >= 2) begin
      chk("t1_first_pop_cycle", pop_cyc[0], c0 + 1);
      chk("t1_second_pop_cycle", pop_cyc[1], c0 + 2);
    end

    // rr_ptr should now be 3: inputs 1 and 4 -> 4 wins first
    clear_logs();
    load_flits(1, 1, 2, 0, 0);
    load_flits(4, 1, 2, 0, 0);
    req_en = 5'b10010;
    refresh();
    exp_pkt(4, 1, 2);
    exp_pkt(1, 1, 2);
    run(4);
    chk_pops("rr_after_t1", 4, 1, 0, 0, 0, 2);

    // Input 1 four-flit packet, input 3 keeps requesting (rr_ptr=2)
    clear_logs();
    load_flits(1, 4, 0, 0, 3);
    req_en = 5'b00010;
    refresh();
    exp_pkt(1, 4, 0);
    cycle();
    chk("t2_locked_owner", {29'b0, grant_owner}, 1);
    chk("t2_locked", {31'b0, dbg_locked}, 1);
    for (int s = 0; s < 3; s++) begin
      load_flits(3, 1, 4 + s, 0, 0);
      exp_pkt(3, 1, 4 + s);
    end
    req_en = 5'b01010;
    refresh();
    run(8);
    chk_pops("t2_pops", 1, 1, 1, 1, 3, 7);
    if (pop_src.size() == 7) begin
      for (int k = 5; k < 7; k++) chk("t2_src_tail", pop_src[k], 3);
    end
    chk_contig("t2_contiguous");

    // Owner empties mid-packet for 3 cycles (rr_ptr=4; input 2 waits)
    clear_logs();
    load_flits(0, 4, 2, 0, 1);
    load_flits(2, 1, 6, 0, 0);
    req_en = 5'b00101;
    refresh();
    exp_pkt(0, 4, 2);
    exp_pkt(2, 1, 6);
    run(2);
    chk("t3_pops_before_stall", pop_src.size(), 2);
    run(3);
    chk("t3_no_pop_during_stall", pop_src.size(), 2);
    chk("t3_still_locked", {31'b0, dbg_locked}, 1);
    load_flits(0, 4, 2, 2, 3);
    run(5);
    chk_pops("t3_pops", 0, 0, 0, 0, 2, 5);

    // Backpressure: out_ready low for 5 cycles with a flit held (rr_ptr=3)
    clear_logs();
    load_flits(3, 3, 1, 0, 2);
    req_en = 5'b01000;
    refresh();
    exp_pkt(3, 3, 1);
    cycle();
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'b0, out_valid}, 1);
      chk("t4_hold_data", {24'b0, out_data}, {24'b0, mk_flit(3, 0, 3, 1)});
      chk("t4_no_rdreq", {27'b0, in_rdreq}, 0);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_pop_on_ready", {27'b0, in_rdreq}, 32'h08);
    run(4);
    chk_pops("t4_pops", 3, 3, 3, 0, 0, 3);

    // All inputs request two single-flit packets each (rr_ptr=4)
    clear_logs();
    for (int s = 0; s < N; s++) load_flits(s, 1, 3, 0, 0);
    for (int s = 0; s < N; s++) load_flits(s, 1, 5, 0, 0);
    req_en = '1;
    refresh();
    for (int k = 0; k < 10; k++) exp_pkt((4 + k) % N, 1, (k < 5) ? 3 : 5);
    run(13);
    chk("t5_count", pop_src.size(), 10);
    if (pop_src.size() == 10) begin
      for (int k = 0; k < 10; k++) chk("t5_rotation", pop_src[k], (4 + k) % N);
    end
    chk_contig("t5_no_gaps");

    // Reset mid-packet drops the lock
    clear_logs();
    load_flits(2, 3, 0, 0, 2);
    req_en = 5'b00100;
    refresh();
    exp_q.push_back(mk_flit(2, 0, 3, 0));
    exp_q.push_back(mk_flit(2, 1, 3, 0));
    run(2);
    chk("t6_locked_before_rst", {31'b0, dbg_locked}, 1);
    rst = 1'b1;
    req_en = '0;
    for (int i = 0; i < N; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end
    refresh();
    cycle();
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 0);
    chk("t6_rst_locked", {31'b0, dbg_locked}, 0);
    chk("t6_rst_owner", {29'b0, grant_owner}, 0);
    clear_logs();
    load_flits(4, 1, 7, 0, 0);
    req_en = 5'b10000;
    refresh();
    exp_pkt(4, 1, 7);
    run(3);
    chk_pops("t6_after_rst", 4, 0, 0, 0, 0, 1);

    // Owner stalls empty for longer than TimeoutCycles
    clear_logs();
    load_flits(0, 2, 1, 0, 0);
    req_en = 5'b00001;
    refresh();
    exp_pkt(0, 2, 1);
    cycle();
    run(5);
    chk("t7_no_err_early", {31'b0, err_timeout}, 0);
    run(7);
`ifdef ROUTER_ARB_WATCHDOG_EN
    chk("t7_err_set", {31'b0, err_timeout}, 1);
`else
    chk("t7_err_tied_low", {31'b0, err_timeout}, 0);
`endif
    load_flits(0, 2, 1, 1, 1);
    run(3);
    chk_pops("t7_pops", 0, 0, 0, 0, 0, 2);
`ifdef ROUTER_ARB_WATCHDOG_EN
    chk("t7_err_sticky", {31'b0, err_timeout}, 1);
`else
    chk("t7_err_still_low", {31'b0, err_timeout}, 0);
`endif
    do_reset();
    chk("t7_err_cleared_by_rst", {31'b0, err_timeout}, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
